// File: rtl/cpu_defs.sv
// Shared definitions for the myCPU multi-cycle divider.
package cpu_defs;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } div_state_e;

    localparam int DIV_WIDTH   = 32;
    localparam int DIV_LATENCY = 33;

endpackage

// File: rtl/div_sub_stage.sv
// One restoring-division step: trial subtract of the divisor from the
// shifted partial remainder, keeping the difference when it is non-negative.
module div_sub_stage #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_sh_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH:0]   rem_nx_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] diff;

    // The shifted remainder is below twice the divisor, so WIDTH+1 bits
    // are enough for the sign of the difference to be exact.
    assign diff     = rem_sh_i - {1'b0, dvs_i};
    assign q_bit_o  = ~diff[WIDTH];
    assign rem_nx_o = q_bit_o ? diff : rem_sh_i;

endmodule

// File: rtl/div_iter.sv
// Radix-2 restoring divider for DIV/DIVU: quotient goes to LO, remainder to HI.
// One setup-free iteration per cycle plus a sign-fix cycle before FIN.
module div_iter
    import cpu_defs::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    div_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] remo_q, remo_d;

    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] rem_nx;
    logic           q_bit;
    logic           accept;
    logic           sgn_a;
    logic           sgn_b;
    logic           unused_msb;

    // Partial remainder is always below the divisor, so its MSB never feeds the shift.
    assign rem_sh     = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
    assign unused_msb = rem_q[WIDTH];

    div_sub_stage #(.WIDTH(WIDTH)) u_sub (
        .rem_sh_i (rem_sh),
        .dvs_i    (dvs_q),
        .rem_nx_o (rem_nx),
        .q_bit_o  (q_bit)
    );

    assign sgn_a  = div_signed & dividend[WIDTH-1];
    assign sgn_b  = div_signed & divisor[WIDTH-1];
    assign accept = start & ~cancel & (state_q == IDLE || state_q == FIN);

    assign busy      = (state_q == CALC);
    assign done      = (state_q == FIN) & ~cancel;
    assign quotient  = quo_q;
    assign remainder = remo_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        quo_d   = quo_q;
        remo_d  = remo_q;
        if (accept) begin
            state_d = CALC;
            cnt_d   = '0;
            rem_d   = '0;
            dvd_d   = sgn_a ? -dividend : dividend;
            dvs_d   = sgn_b ? -divisor : divisor;
            negq_d  = sgn_a ^ sgn_b;
            negr_d  = sgn_a;
        end else if (cancel && state_q != IDLE) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                CALC: begin
                    if (cnt_q == CNT_W'(WIDTH)) begin
                        state_d = FIN;
                        quo_d   = negq_q ? -dvd_q : dvd_q;
                        remo_d  = negr_q ? -rem_q[WIDTH-1:0]
                                         : rem_q[WIDTH-1:0];
                    end else begin
                        rem_d = rem_nx;
                        dvd_d = {dvd_q[WIDTH-2:0], q_bit};
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                FIN:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            quo_q   <= '0;
            remo_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            quo_q   <= quo_d;
            remo_q  <= remo_d;
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter: expected {quotient, remainder} are queued
// at start and popped when done is seen.
module tb_div_iter;
    import cpu_defs::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         start = 1'b0;
    logic         div_signed = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         cancel = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;

    int n_vec = 0;
    int n_err = 0;
    logic [63:0] sb_q[$];
    logic [W-1:0] last_q = '0;
    logic [W-1:0] last_r = '0;

    div_iter dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .div_signed (div_signed),
        .dividend   (dividend),
        .divisor    (divisor),
        .cancel     (cancel),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic s,
                                          input logic [W-1:0] a,
                                          input logic [W-1:0] b);
        logic [W-1:0] ma, mb, q, r;
        ma = (s && a[W-1]) ? -a : a;
        mb = (s && b[W-1]) ? -b : b;
        q  = (mb == 0) ? '1 : ma / mb;
        r  = (mb == 0) ? ma : ma % mb;
        if (s && (a[W-1] ^ b[W-1])) q = -q;
        if (s && a[W-1]) r = -r;
        return {q, r};
    endfunction

    always @(negedge clk) begin
        if (done) begin
            if (sb_q.size() == 0) begin
                chk("unexp_done", 64'(done), 64'd0);
            end else begin
                logic [63:0] e;
                e = sb_q.pop_front();
                chk("quotient", 64'(quotient), 64'(e[63:32]));
                chk("remainder", 64'(remainder), 64'(e[31:0]));
            end
        end
    end

    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run(input logic s, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [63:0] e);
        int lat;
        sb_q.push_back(e);
        div_signed = s;
        dividend   = a;
        divisor    = b;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat);
        chk("latency", 64'(lat), 64'(DIV_LATENCY));
        last_q = e[63:32];
        last_r = e[31:0];
        @(posedge clk); #1;
    endtask

    initial begin
        int lat;
        logic [W-1:0] ra, rb;
        logic s;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_q", 64'(quotient), 64'd0);
        chk("rst_r", 64'(remainder), 64'd0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // DIVU 100/7 with busy probes
        sb_q.push_back({32'd14, 32'd2});
        div_signed = 1'b0; dividend = 100; divisor = 7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("busy_first", 64'(busy), 64'd1);
        repeat (32) @(negedge clk);
        chk("busy_last", 64'(busy), 64'd1);
        chk("done_early", 64'(done), 64'd0);
        @(negedge clk);
        chk("done_e33", 64'(done), 64'd1);
        chk("busy_fin", 64'(busy), 64'd0);
        last_q = 14; last_r = 2;
        @(posedge clk); #1;

        run(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFD, 32'hFFFF_FFFF});
        run(1'b1, 32'd7, 32'hFFFF_FFFE, {32'hFFFF_FFFD, 32'd1});
        run(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'd0});
        run(1'b0, 32'h1234_5678, 32'd0, {32'hFFFF_FFFF, 32'h1234_5678});
        run(1'b1, 32'hFFFF_FFF9, 32'd0, model(1'b1, 32'hFFFF_FFF9, 32'd0));
        run(1'b0, 32'hFFFF_FFFF, 32'd1, {32'hFFFF_FFFF, 32'd0});
        for (int i = 0; i < 6; i++) begin
            s  = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 28);
            run(s, ra, rb, model(s, ra, rb));
        end

        // cancel mid-CALC: no done, outputs held
        div_signed = 1'b0; dividend = 50; divisor = 5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        @(negedge clk);
        chk("cancel_busy", 64'(busy), 64'd0);
        chk("cancel_q", 64'(quotient), 64'(last_q));
        chk("cancel_r", 64'(remainder), 64'(last_r));
        repeat (40) @(posedge clk);
        #1;
        chk("cancel_hold_q", 64'(quotient), 64'(last_q));

        // cancel beats start in the same cycle
        start = 1'b1; cancel = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; cancel = 1'b0;
        @(negedge clk);
        chk("cancel_prio", 64'(busy), 64'd0);
        @(posedge clk); #1;
        run(1'b0, 32'd9, 32'd4, {32'd2, 32'd1});

        // start during CALC is ignored, start during FIN is accepted
        sb_q.push_back({32'd6, 32'd2});
        div_signed = 1'b0; dividend = 20; divisor = 3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        dividend = 8; divisor = 2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat);
        chk("lat_ignore", 64'(lat), 64'(DIV_LATENCY - 6));
        sb_q.push_back({32'd4, 32'd0});
        dividend = 8; divisor = 2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_busy", 64'(busy), 64'd1);
        wait_done(lat);
        chk("lat_b2b", 64'(lat), 64'(DIV_LATENCY));
        @(posedge clk); #1;

        // asynchronous reset mid-CALC
        dividend = 1000; divisor = 3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_q", 64'(quotient), 64'd0);
        chk("arst_r", 64'(remainder), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        run(1'b0, 32'd15, 32'd4, {32'd3, 32'd3});

        repeat (3) @(posedge clk);
        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
